fb_write_arbiter3: RTL and testbench
====================================

Name: fb_write_arbiter3

Overview:
- Shares one frame-buffer write port among three OV7670 capture channels in the triple-camera QQVGA design.
- Each channel's per-pixel write strobe, pixel address and RGB444/gray word is queued in a small per-channel FIFO.
- A round-robin scheduler drains the FIFOs, one memory write per clk.
- Each camera's pixel address is relocated into its own region of a single concatenated buffer (camera i at base i*c_img_pxls).

Parameters:
c_img_pxls, 19200, pixels per camera image (160x120)
c_nb_img_pxls, 15, width of camera pixel address
c_nb_mem_addr, 16, width of shared buffer address (holds 3*c_img_pxls)
c_nb_buf, 12, pixel word width
c_nb_fifo, 2, log2 of per-channel FIFO depth (depth 4)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset
cam_we  in  3  per-camera write strobe, one clk pulse per pixel, bit i = camera i
cam_addr0  in  c_nb_img_pxls  camera 0 pixel address
cam_addr1  in  c_nb_img_pxls  camera 1 pixel address
cam_addr2  in  c_nb_img_pxls  camera 2 pixel address
cam_dout0  in  c_nb_buf  camera 0 pixel word
cam_dout1  in  c_nb_buf  camera 1 pixel word
cam_dout2  in  c_nb_buf  camera 2 pixel word
cam_newframe  in  3  per-camera new-frame pulse
enable  in  3  per-camera accept enable
clr_err  in  1  clears the sticky error flags
mem_we  out  1  shared buffer write enable, registered
mem_addr  out  c_nb_mem_addr  shared buffer write address, registered
mem_din  out  c_nb_buf  shared buffer write data, registered
overflow  out  3  sticky flag: pixel dropped because the FIFO was full
range_err  out  3  sticky flag: pixel dropped because the address was out of range
frame_tgl  out  3  toggles on each cam_newframe[i]

Behaviour:
Reset and clocking:
- rst is asynchronous, active-high; clock is clk.
- During reset all outputs are 0, all FIFOs are empty and last_gnt = 2, so camera 0 has first priority after release.
- Reset mid-operation discards all queued pixels; mem_we drops to 0 immediately.

Push (per channel i, evaluated every clk edge):
- A push is attempted when cam_we[i] = 1 and enable[i] = 1.
- If cam_addr_i >= c_img_pxls: no push; range_err[i] <= 1.
- Else if the FIFO is full and no pop of channel i occurs this cycle: no push; overflow[i] <= 1.
- Otherwise: push the pair {cam_addr_i, cam_dout_i}.
- Full FIFO with a simultaneous push and pop: push is accepted and the count is unchanged.
- Empty FIFO: push and pop cannot coincide, because pop only occurs from a non-empty FIFO.

Scheduler:
- Request i = FIFO i not empty.
- Search order is last_gnt+1, last_gnt+2, last_gnt (mod 3). The first requester found is granted, its FIFO is popped and last_gnt <= granted index.
- No request: last_gnt is held.

Output stage (registered):
- On a grant of channel g: mem_we <= 1, mem_addr <= g*c_img_pxls + popped address (zero-extended), mem_din <= popped data.
- No grant: mem_we <= 0; mem_addr and mem_din hold their values.
- Arithmetic is unsigned. Base offsets are the constants 0, 19200 and 38400. Maximum address is 57599 and fits in 16 bits.

Latency and throughput:
- cam_we[i] high in cycle t with channel i uncontested gives mem_we high in cycle t+2.
- Sustained throughput is one write per clk.
- Each camera issues at most one pixel per 8 clks (2 pclk per pixel, pclk at least 4 clk), so depth 4 never overflows in normal operation.

Enable:
- Deasserting enable[i] blocks new pushes only; entries already queued still drain.
- cam_we[i] while enable[i] = 0 is ignored and sets no flags.

Frame toggle and error flags:
- cam_newframe[i] toggles frame_tgl[i] regardless of enable. FIFOs are not flushed.
- clr_err clears overflow and range_err in the next cycle.
- If clr_err coincides with a new error event, the flag is set (set wins).

Test Plan:
1. Reset release; cam_we = 3'b010, cam_addr1 = 5, cam_dout1 = 12'hABC in cycle t -> cycle t+2: mem_we = 1, mem_addr = 19205, mem_din = 12'hABC; cycle t+3: mem_we = 0.
2. cam_we = 3'b111, all addresses 0, data 1/2/3 in cycle t -> writes at t+2, t+3, t+4 with addresses 0, 19200, 38400 and data 1, 2, 3, in that order.
3. All three cameras strobe every clk for 10 cycles, addresses incrementing from 0 -> overflow = 3'b111; every mem write is unique and address-ordered per camera; total writes = pushes accepted; clr_err pulse -> overflow = 0.
4. cam_we[2] with cam_addr2 = 19200 -> no mem_we; range_err = 3'b100. Then cam_addr2 = 19199 -> mem_addr = 57599.
5. Queue 2 entries on camera 1, drop enable[1] the next cycle while cam_we[1] keeps pulsing -> exactly 2 writes; no flags set.
6. Assert rst asynchronously with 3 entries queued -> mem_we = 0 immediately. After release, simultaneous requests from cameras 0 and 2 -> camera 0 is granted first, then camera 2.

Source files
------------

// File: rtl/fb_write_arbiter3.sv
// Frame-buffer write arbiter for the triple-camera QQVGA capture path.
// Each camera pushes {pixel address, pixel word} into its own small FIFO;
// a round-robin scheduler drains one entry per clk into a registered write
// port, relocating each camera's address into its own buffer region.

// One capture channel: range check, FIFO, sticky error flags, frame toggle.
module fb_wa_chan #(
    parameter int c_img_pxls    = 19200,
    parameter int c_nb_img_pxls = 15,
    parameter int c_nb_buf      = 12,
    parameter int c_nb_fifo     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     en,
    input  logic [c_nb_img_pxls-1:0] addr,
    input  logic [c_nb_buf-1:0]      din,
    input  logic                     pop,
    input  logic                     newframe,
    input  logic                     clr_err,
    output logic                     req,
    output logic [c_nb_img_pxls-1:0] rd_addr,
    output logic [c_nb_buf-1:0]      rd_data,
    output logic                     overflow,
    output logic                     range_err,
    output logic                     frame_tgl
);
    localparam int DEPTH = 1 << c_nb_fifo;
    localparam int EW    = c_nb_img_pxls + c_nb_buf;
    localparam logic [c_nb_img_pxls-1:0] IMG_LIM  = c_nb_img_pxls'(c_img_pxls);
    localparam logic [c_nb_fifo:0]       FULL_CNT = (c_nb_fifo + 1)'(DEPTH);

    logic [EW-1:0]          mem_q [DEPTH];
    logic [c_nb_fifo-1:0]   wr_ptr_q, rd_ptr_q;
    logic [c_nb_fifo:0]     cnt_q, cnt_d;
    logic                   ovf_q, ovf_d, rerr_q, rerr_d, tgl_q;
    logic                   attempt, bad_addr, full, drop_full, push;

    // A full FIFO still accepts a push when the same cycle pops it.
    always_comb begin
        attempt   = we & en;
        bad_addr  = attempt & (addr >= IMG_LIM);
        full      = (cnt_q == FULL_CNT);
        drop_full = attempt & ~bad_addr & full & ~pop;
        push      = attempt & ~bad_addr & ~drop_full;
        cnt_d     = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // clear first so a coincident error event wins
        ovf_d  = clr_err ? 1'b0 : ovf_q;
        rerr_d = clr_err ? 1'b0 : rerr_q;
        if (drop_full) ovf_d  = 1'b1;
        if (bad_addr)  rerr_d = 1'b1;
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {addr, din};
    end

    // FIFO pointers, occupancy, sticky flags and frame toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            rerr_q   <= 1'b0;
            tgl_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            rerr_q <= rerr_d;
            tgl_q  <= tgl_q ^ newframe;
        end
    end

    assign req       = (cnt_q != '0);
    assign rd_addr   = mem_q[rd_ptr_q][EW-1:c_nb_buf];
    assign rd_data   = mem_q[rd_ptr_q][c_nb_buf-1:0];
    assign overflow  = ovf_q;
    assign range_err = rerr_q;
    assign frame_tgl = tgl_q;
endmodule

module fb_write_arbiter3 #(
    parameter int c_img_pxls    = 19200,
    parameter int c_nb_img_pxls = 15,
    parameter int c_nb_mem_addr = 16,
    parameter int c_nb_buf      = 12,
    parameter int c_nb_fifo     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               cam_we,
    input  logic [c_nb_img_pxls-1:0] cam_addr0,
    input  logic [c_nb_img_pxls-1:0] cam_addr1,
    input  logic [c_nb_img_pxls-1:0] cam_addr2,
    input  logic [c_nb_buf-1:0]      cam_dout0,
    input  logic [c_nb_buf-1:0]      cam_dout1,
    input  logic [c_nb_buf-1:0]      cam_dout2,
    input  logic [2:0]               cam_newframe,
    input  logic [2:0]               enable,
    input  logic                     clr_err,
    output logic                     mem_we,
    output logic [c_nb_mem_addr-1:0] mem_addr,
    output logic [c_nb_buf-1:0]      mem_din,
    output logic [2:0]               overflow,
    output logic [2:0]               range_err,
    output logic [2:0]               frame_tgl
);
    localparam int NCH = 3;
    localparam logic [c_nb_mem_addr-1:0] BASE1 = c_nb_mem_addr'(c_img_pxls);
    localparam logic [c_nb_mem_addr-1:0] BASE2 = c_nb_mem_addr'(2 * c_img_pxls);

    logic [NCH-1:0][c_nb_img_pxls-1:0] addr_in, rd_addr;
    logic [NCH-1:0][c_nb_buf-1:0]      din_in, rd_data;
    logic [NCH-1:0]                    req, pop;

    logic [1:0]               last_gnt_q, last_gnt_d;
    logic [1:0]               gnt_idx, c1, c2;
    logic                     gnt_vld;
    logic [c_nb_mem_addr-1:0] base;
    logic                     mem_we_q, mem_we_d;
    logic [c_nb_mem_addr-1:0] mem_addr_q, mem_addr_d;
    logic [c_nb_buf-1:0]      mem_din_q, mem_din_d;

    assign addr_in = {cam_addr2, cam_addr1, cam_addr0};
    assign din_in  = {cam_dout2, cam_dout1, cam_dout0};

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        fb_wa_chan #(
            .c_img_pxls   (c_img_pxls),
            .c_nb_img_pxls(c_nb_img_pxls),
            .c_nb_buf     (c_nb_buf),
            .c_nb_fifo    (c_nb_fifo)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .we       (cam_we[gi]),
            .en       (enable[gi]),
            .addr     (addr_in[gi]),
            .din      (din_in[gi]),
            .pop      (pop[gi]),
            .newframe (cam_newframe[gi]),
            .clr_err  (clr_err),
            .req      (req[gi]),
            .rd_addr  (rd_addr[gi]),
            .rd_data  (rd_data[gi]),
            .overflow (overflow[gi]),
            .range_err(range_err[gi]),
            .frame_tgl(frame_tgl[gi])
        );
    end

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Round-robin grant: search starts just after the last winner, which
    // itself is checked last.
    always_comb begin
        c1      = inc3(last_gnt_q);
        c2      = inc3(c1);
        gnt_vld = 1'b1;
        gnt_idx = last_gnt_q;
        if (req[c1])              gnt_idx = c1;
        else if (req[c2])         gnt_idx = c2;
        else if (req[last_gnt_q]) gnt_idx = last_gnt_q;
        else                      gnt_vld = 1'b0;
        pop        = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;
        last_gnt_d = gnt_vld ? gnt_idx : last_gnt_q;
    end

    // Relocate the popped pixel address into the winner's buffer region.
    always_comb begin
        case (gnt_idx)
            2'd0:    base = '0;
            2'd1:    base = BASE1;
            default: base = BASE2;
        endcase
        mem_we_d   = gnt_vld;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (gnt_vld) begin
            mem_addr_d = base + c_nb_mem_addr'(rd_addr[gnt_idx]);
            mem_din_d  = rd_data[gnt_idx];
        end
    end

    // Scheduler state and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 2'd2;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
endmodule

// File: tb/tb_fb_write_arbiter3.sv
// Bench for fb_write_arbiter3: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a queue-based model.
module tb_fb_write_arbiter3;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cam_we, cam_newframe, enable;
    logic [14:0] cam_addr0, cam_addr1, cam_addr2;
    logic [11:0] cam_dout0, cam_dout1, cam_dout2;
    logic        clr_err;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [11:0] mem_din;
    logic [2:0]  overflow, range_err, frame_tgl;

    fb_write_arbiter3 dut (
        .clk(clk), .rst(rst), .cam_we(cam_we),
        .cam_addr0(cam_addr0), .cam_addr1(cam_addr1), .cam_addr2(cam_addr2),
        .cam_dout0(cam_dout0), .cam_dout1(cam_dout1), .cam_dout2(cam_dout2),
        .cam_newframe(cam_newframe), .enable(enable), .clr_err(clr_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .overflow(overflow), .range_err(range_err), .frame_tgl(frame_tgl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [26:0] mq[3][$];
    int          m_last;
    logic        m_we;
    logic [15:0] m_addr;
    logic [11:0] m_din;
    logic [2:0]  m_ovf, m_rerr, m_tgl;
    bit          model_on = 0;

    function automatic logic [14:0] cam_a(input int i);
        return (i == 0) ? cam_addr0 : (i == 1) ? cam_addr1 : cam_addr2;
    endfunction
    function automatic logic [11:0] cam_d(input int i);
        return (i == 0) ? cam_dout0 : (i == 1) ? cam_dout1 : cam_dout2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_last = 2; m_we = 0; m_addr = 0; m_din = 0;
        m_ovf = 0; m_rerr = 0; m_tgl = 0;
    endtask

    task automatic model_step();
        int g;
        int c;
        logic [14:0] a;
        logic [26:0] e;
        logic [2:0]  acc;
        logic [26:0] nw[3];
        g = -1;
        for (int k = 1; k <= 3; k++) begin
            c = (m_last + k) % 3;
            if (g < 0 && mq[c].size() > 0) g = c;
        end
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            nw[i] = 0;
            if (clr_err) begin m_ovf[i] = 0; m_rerr[i] = 0; end
            if (cam_we[i] && enable[i]) begin
                a = cam_a(i);
                if (int'(a) >= 19200) m_rerr[i] = 1;
                else if (mq[i].size() == 4 && g != i) m_ovf[i] = 1;
                else begin acc[i] = 1; nw[i] = {a, cam_d(i)}; end
            end
        end
        if (g >= 0) begin
            e = mq[g].pop_front();
            m_we = 1;
            m_addr = 16'(g * 19200 + int'(e[26:12]));
            m_din = e[11:0];
            m_last = g;
        end else m_we = 0;
        for (int i = 0; i < 3; i++) if (acc[i]) mq[i].push_back(nw[i]);
        m_tgl = m_tgl ^ cam_newframe;
    endtask

    // Inputs are driven 1 time unit after an edge; outputs sampled there too.
    task automatic tick();
        if (model_on) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cam_we = 0; cam_newframe = 0; enable = 3'b111; clr_err = 0;
        cam_addr0 = 0; cam_addr1 = 0; cam_addr2 = 0;
        cam_dout0 = 0; cam_dout1 = 0; cam_dout2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // write collection for the hand sequences
    int wcnt;
    int wcam[3];
    int wlast[3];
    task automatic collect();
        int cam, loc;
        if (mem_we) begin
            cam = int'(mem_addr) / 19200;
            loc = int'(mem_addr) % 19200;
            wcnt++;
            if (cam < 3) begin
                wcam[cam]++;
                chk("burst_order", 32'(loc > wlast[cam]), 32'd1);
                chk("burst_data", 32'(mem_din), 32'({cam[3:0], loc[7:0]}));
                wlast[cam] = loc;
            end else chk("burst_cam_range", 32'(cam), 32'd2);
        end
    endtask
    task automatic clear_collect();
        wcnt = 0;
        for (int i = 0; i < 3; i++) begin wcam[i] = 0; wlast[i] = -1; end
    endtask

    typedef struct {
        logic [2:0]  we;
        logic [14:0] addr;
        logic [11:0] data;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [2:0]  exp_rerr;
    } vec_t;
    vec_t vt[7];

    int load;

    initial begin
        idle_inputs();
        rst = 1;
        #1;
        chk("reset_we", 32'(mem_we), 0);
        chk("reset_addr", 32'(mem_addr), 0);
        chk("reset_din", 32'(mem_din), 0);
        chk("reset_flags", 32'({overflow, range_err, frame_tgl}), 0);
        do_reset();

        // ---- directed single-pixel vectors ----
        vt[0] = '{3'b010, 15'd5,     12'hABC, 1'b1, 16'd19205, 3'b000};
        vt[1] = '{3'b100, 15'd19200, 12'h111, 1'b0, 16'd0,     3'b100};
        vt[2] = '{3'b100, 15'd19199, 12'hFFF, 1'b1, 16'd57599, 3'b000};
        vt[3] = '{3'b001, 15'd19199, 12'h5A5, 1'b1, 16'd19199, 3'b000};
        vt[4] = '{3'b001, 15'd0,     12'h123, 1'b1, 16'd0,     3'b000};
        vt[5] = '{3'b010, 15'd32767, 12'h222, 1'b0, 16'd0,     3'b010};
        vt[6] = '{3'b010, 15'd0,     12'h0F0, 1'b1, 16'd19200, 3'b000};
        for (int v = 0; v < 7; v++) begin
            cam_we = vt[v].we;
            cam_addr0 = vt[v].addr; cam_addr1 = vt[v].addr; cam_addr2 = vt[v].addr;
            cam_dout0 = vt[v].data; cam_dout1 = vt[v].data; cam_dout2 = vt[v].data;
            tick();
            cam_we = 0;
            tick();
            chk($sformatf("vec%0d_we", v), 32'(mem_we), 32'(vt[v].exp_we));
            if (vt[v].exp_we) begin
                chk($sformatf("vec%0d_addr", v), 32'(mem_addr), 32'(vt[v].exp_addr));
                chk($sformatf("vec%0d_din", v), 32'(mem_din), 32'(vt[v].data));
            end
            chk($sformatf("vec%0d_rerr", v), 32'(range_err), 32'(vt[v].exp_rerr));
            tick();
            chk($sformatf("vec%0d_we_off", v), 32'(mem_we), 0);
            clr_err = 1;
            tick();
            clr_err = 0;
            chk($sformatf("vec%0d_rerr_clr", v), 32'(range_err), 0);
        end

        // frame toggle ignores enable
        enable = 3'b000; cam_newframe = 3'b010;
        tick();
        cam_newframe = 0; enable = 3'b111;
        chk("frame_tgl", 32'(frame_tgl), 32'd2);

        // ---- three simultaneous pixels after reset: order 0,1,2 ----
        do_reset();
        cam_we = 3'b111; cam_dout0 = 1; cam_dout1 = 2; cam_dout2 = 3;
        tick();
        cam_we = 0;
        tick();
        chk("tri0_we", 32'(mem_we), 1);
        chk("tri0", 32'({mem_addr, mem_din}), 32'({16'd0, 12'd1}));
        tick();
        chk("tri1", 32'({mem_addr, mem_din}), 32'({16'd19200, 12'd2}));
        tick();
        chk("tri2", 32'({mem_addr, mem_din}), 32'({16'd38400, 12'd3}));
        tick();
        chk("tri_we_off", 32'(mem_we), 0);

        // ---- burst overload on all cameras ----
        do_reset();
        clear_collect();
        for (int i = 0; i < 10; i++) begin
            cam_we = 3'b111;
            cam_addr0 = 15'(i); cam_addr1 = 15'(i); cam_addr2 = 15'(i);
            cam_dout0 = {4'd0, 8'(i)}; cam_dout1 = {4'd1, 8'(i)}; cam_dout2 = {4'd2, 8'(i)};
            tick();
            collect();
        end
        cam_we = 0;
        for (int i = 0; i < 30; i++) begin tick(); collect(); end
        chk("burst_total", 32'(wcnt), 32'd21);
        for (int i = 0; i < 3; i++) chk($sformatf("burst_cam%0d", i), 32'(wcam[i]), 32'd7);
        chk("burst_ovf", 32'(overflow), 32'd7);
        clr_err = 1;
        tick();
        clr_err = 0;
        chk("burst_ovf_clr", 32'(overflow), 0);

        // ---- enable drop: queued entries drain, new strobes ignored ----
        do_reset();
        clear_collect();
        cam_we = 3'b010;
        for (int i = 0; i < 8; i++) begin
            cam_addr1 = 15'(i);
            cam_dout1 = {4'd1, 8'(i)};
            if (i == 2) enable = 3'b101;
            tick();
            collect();
        end
        cam_we = 0;
        for (int i = 0; i < 6; i++) begin tick(); collect(); end
        chk("en_writes", 32'(wcnt), 32'd2);
        chk("en_flags", 32'({overflow, range_err}), 0);
        enable = 3'b111;

        // ---- async reset with entries queued, then priority after release ----
        do_reset();
        cam_we = 3'b111;
        tick();
        cam_we = 0;
        tick();
        chk("ar_pre_we", 32'(mem_we), 1);
        #2 rst = 1;
        #1;
        chk("ar_we_now", 32'(mem_we), 0);
        chk("ar_addr_now", 32'(mem_addr), 0);
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_flushed", 32'(mem_we), 0);
        end
        cam_we = 3'b101; cam_addr0 = 7; cam_addr2 = 9; cam_dout0 = 12'h070; cam_dout2 = 12'h290;
        tick();
        cam_we = 0;
        tick();
        chk("ar_first", 32'({mem_we, mem_addr}), 32'({1'b1, 16'd7}));
        tick();
        chk("ar_second", 32'({mem_we, mem_addr}), 32'({1'b1, 16'd38409}));
        tick();
        chk("ar_done", 32'(mem_we), 0);

        // ---- random traffic against the model ----
        do_reset();
        model_reset();
        model_on = 1;
        for (int n = 0; n < 3000; n++) begin
            load = (n < 1500) ? 35 : 15;
            for (int i = 0; i < 3; i++) cam_we[i] = ($urandom_range(0, 99) < load);
            cam_addr0 = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(19200, 32767)) : 15'($urandom_range(0, 19199));
            cam_addr1 = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(19200, 32767)) : 15'($urandom_range(0, 19199));
            cam_addr2 = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(19200, 32767)) : 15'($urandom_range(0, 19199));
            cam_dout0 = 12'($urandom); cam_dout1 = 12'($urandom); cam_dout2 = 12'($urandom);
            for (int i = 0; i < 3; i++) begin
                enable[i] = ($urandom_range(0, 9) != 0);
                cam_newframe[i] = ($urandom_range(0, 19) == 0);
            end
            clr_err = ($urandom_range(0, 29) == 0);
            tick();
            chk("rnd_we", 32'(mem_we), 32'(m_we));
            chk("rnd_addr", 32'(mem_addr), 32'(m_addr));
            chk("rnd_din", 32'(mem_din), 32'(m_din));
            chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
            chk("rnd_rerr", 32'(range_err), 32'(m_rerr));
            chk("rnd_tgl", 32'(frame_tgl), 32'(m_tgl));
        end
        model_on = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
